// File: rtl/core_sram_arbiter.sv
// Single-port SRAM arbiter between a Wishbone slave port and a core data port.
// Optional contention counter enabled by defining CORE_SRAM_ARB_CONFLICT_CNT_EN.
module core_sram_arbiter #(
  parameter int AW       = 10,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [3:0]    core_be_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [31:0]   core_wdata_i,
  output logic          core_gnt_o,
  output logic          core_rvalid_o,
  output logic [31:0]   core_rdata_o,
  output logic          sram_en_o,
  output logic          sram_we_o,
  output logic [3:0]    sram_be_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o,
  input  logic [31:0]   sram_rdata_i,
  output logic [15:0]   conflict_cnt_o
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, WB_ACK} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          wb_req, starve, wb_gnt, core_gnt;
  logic          vld_p1;
  logic          wb_we_p1;

  function automatic logic [WW-1:0] sat_wait_inc(input logic [WW-1:0] v);
    if (v == WW'(MAX_WAIT)) return v;
    return v + WW'(1);
  endfunction

  // Grants are suppressed while reset is held so the SRAM sees no access.
  always_comb begin
    wb_req   = wbs_cyc_i & wbs_stb_i & (state_q == IDLE) & rst_ni;
    starve   = (wait_cnt_q == WW'(MAX_WAIT));
    wb_gnt   = wb_req & (~core_req_i | starve);
    core_gnt = core_req_i & rst_ni & ~wb_gnt;
  end

  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (wb_gnt) begin
      sram_en_o    = 1'b1;
      sram_we_o    = wbs_we_i;
      sram_be_o    = wbs_sel_i;
      sram_addr_o  = wbs_adr_i;
      sram_wdata_o = wbs_dat_i;
    end else if (core_gnt) begin
      sram_en_o    = 1'b1;
      sram_we_o    = core_we_i;
      sram_be_o    = core_be_i;
      sram_addr_o  = core_addr_i;
      sram_wdata_o = core_wdata_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE:    if (wb_gnt) state_d = WB_ACK;
      WB_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!wb_req || wb_gnt) begin
      wait_cnt_d = '0;
    end else if (core_gnt) begin
      wait_cnt_d = sat_wait_inc(wait_cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      vld_p1     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      vld_p1     <= core_gnt;
    end
  end

  // p0 -> p1: remember the direction of the granted Wishbone access for the ack cycle.
  always_ff @(posedge clk_i) begin
    if (wb_gnt) wb_we_p1 <= wbs_we_i;
  end

  assign wbs_ack_o     = (state_q == WB_ACK);
  assign wbs_dat_o     = (wbs_ack_o && !wb_we_p1) ? sram_rdata_i : 32'h0;
  assign core_gnt_o    = core_gnt;
  assign core_rvalid_o = vld_p1;
  assign core_rdata_o  = vld_p1 ? sram_rdata_i : 32'h0;

`ifdef CORE_SRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q;

  function automatic logic [15:0] sat_cnt_inc(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
    end else if (wb_req && core_req_i) begin
      conflict_cnt_q <= sat_cnt_inc(conflict_cnt_q);
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_core_sram_arbiter.sv
// Scoreboard bench for core_sram_arbiter with a behavioural single-port SRAM.
module tb_core_sram_arbiter;

  localparam int AW = 10;

  logic          clk, rst_n;
  logic          wbs_cyc, wbs_stb, wbs_we;
  logic [3:0]    wbs_sel;
  logic [AW-1:0] wbs_adr;
  logic [31:0]   wbs_dat_w, wbs_dat_r;
  logic          wbs_ack;
  logic          core_req, core_we;
  logic [3:0]    core_be;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata, core_rdata;
  logic          core_gnt, core_rvalid;
  logic          sram_en, sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic [15:0]   conflict_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] core_q[$];
  logic [31:0] wb_q[$];
  logic [31:0] mem [0:(1<<AW)-1];

  core_sram_arbiter #(.AW(AW), .MAX_WAIT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we), .wbs_sel_i(wbs_sel),
    .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat_w), .wbs_dat_o(wbs_dat_r), .wbs_ack_o(wbs_ack),
    .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
    .core_rdata_o(core_rdata),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_be_o(sram_be), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
    .conflict_cnt_o(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: byte-masked write, read data registered one cycle after enable.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic idle_inputs;
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 0; wbs_adr = 0; wbs_dat_w = 0;
    core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
  endtask

  task automatic wb_read_check(input logic [AW-1:0] a, input logic [31:0] exp, input string nm);
    logic got;
    logic [31:0] e;
    @(negedge clk);
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_sel = 4'hF; wbs_adr = a;
    wb_q.push_back(exp);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk); #1;
      if (wbs_ack) got = 1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_ack_timeout: got no ack, required ack within 8 cycles", nm);
      void'(wb_q.pop_front());
    end else begin
      e = wb_q.pop_front();
      if (wbs_dat_r !== e) begin
        failures++;
        $display("FAIL %s_data: got %h required %h", nm, wbs_dat_r, e);
      end
    end
    wbs_cyc = 0; wbs_stb = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    core_req = 1; core_addr = 10'h7;
    #1;
    checks++; if (wbs_ack !== 1'b0) begin failures++; $display("FAIL rst_ack: got %b required 0", wbs_ack); end
    checks++; if (core_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b required 0", core_rvalid); end
    checks++; if (conflict_cnt !== 16'h0) begin failures++; $display("FAIL rst_conflict: got %h required 0", conflict_cnt); end
    checks++; if (core_gnt !== 1'b0 || sram_en !== 1'b0) begin failures++; $display("FAIL rst_no_grant: got gnt=%b en=%b required 0 0", core_gnt, sram_en); end
    checks++; if (wbs_dat_r !== 32'h0) begin failures++; $display("FAIL rst_wbdat: got %h required 0", wbs_dat_r); end
    core_req = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_core_read;
    logic [31:0] e;
    @(negedge clk);
    core_req = 1; core_we = 1; core_be = 4'hF; core_addr = 10'h005; core_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (core_gnt !== 1'b1 || sram_we !== 1'b1) begin failures++; $display("FAIL core_wr_gnt: got gnt=%b we=%b required 1 1", core_gnt, sram_we); end
    @(negedge clk);
    core_we = 0; core_wdata = 0;
    core_q.push_back(32'hDEADBEEF);
    #1;
    checks++; if (core_gnt !== 1'b1 || sram_en !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 10'h005) begin
      failures++; $display("FAIL core_rd_gnt: got gnt=%b en=%b we=%b addr=%h required 1 1 0 005", core_gnt, sram_en, sram_we, sram_addr); end
    @(negedge clk);
    core_req = 0;
    #1;
    checks++; if (core_rvalid !== 1'b1) begin failures++; $display("FAIL core_rd_rvalid: got %b required 1", core_rvalid); end
    e = core_q.pop_front();
    checks++; if (core_rdata !== e) begin failures++; $display("FAIL core_rd_data: got %h required %h", core_rdata, e); end
    @(negedge clk); #1;
    checks++; if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin failures++; $display("FAIL core_rd_idle: got rvalid=%b rdata=%h required 0 0", core_rvalid, core_rdata); end
  endtask

  task automatic test_wb_write_read;
    @(negedge clk);
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'hF; wbs_adr = 10'h3FF; wbs_dat_w = 32'h12345678;
    #1;
    checks++; if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 10'h3FF || sram_wdata !== 32'h12345678 || sram_be !== 4'hF) begin
      failures++; $display("FAIL wb_wr_sram: got en=%b we=%b addr=%h wdata=%h be=%h required 1 1 3ff 12345678 f", sram_en, sram_we, sram_addr, sram_wdata, sram_be); end
    checks++; if (wbs_ack !== 1'b0) begin failures++; $display("FAIL wb_wr_early_ack: got %b required 0", wbs_ack); end
    @(negedge clk); #1;
    checks++; if (wbs_ack !== 1'b1 || wbs_dat_r !== 32'h0) begin failures++; $display("FAIL wb_wr_ack: got ack=%b dat=%h required 1 0", wbs_ack, wbs_dat_r); end
    checks++; if (sram_en !== 1'b0) begin failures++; $display("FAIL wb_wr_no_regrant: got en=%b required 0", sram_en); end
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
    @(negedge clk); #1;
    checks++; if (wbs_ack !== 1'b0) begin failures++; $display("FAIL wb_wr_ack_single: got %b required 0", wbs_ack); end
    wb_read_check(10'h3FF, 32'h12345678, "wb_rd_3ff");
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] wa [5] = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h013};
    logic [31:0]   wd [5] = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A50003, 32'h5A5ABEEF};
    logic [3:0]    wb [5] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h3};
    logic [31:0]   ex [4] = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A5BEEF};
    logic [31:0]   e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      core_req = 1; core_we = 1; core_be = wb[i]; core_addr = wa[i]; core_wdata = wd[i];
      #1;
      checks++; if (core_gnt !== 1'b1) begin failures++; $display("FAIL b2b_wr_gnt%0d: got %b required 1", i, core_gnt); end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (core_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_rvalid%0d: got %b required 1", i, core_rvalid); end
        e = core_q.pop_front();
        checks++; if (core_rdata !== e) begin failures++; $display("FAIL b2b_rdata%0d: got %h required %h", i, core_rdata, e); end
      end
      if (i < 4) begin
        core_we = 0; core_be = 4'hF; core_wdata = 0; core_addr = 10'h010 + AW'(i);
        core_q.push_back(ex[i]);
        #1;
        checks++; if (core_gnt !== 1'b1) begin failures++; $display("FAIL b2b_rd_gnt%0d: got %b required 1", i, core_gnt); end
      end else begin
        core_req = 0;
      end
    end
  endtask

  task automatic test_starvation;
    logic [31:0] e;
    logic exp_rv;
    @(negedge clk);
    core_req = 1; core_we = 0; core_be = 4'hF; core_addr = 10'h001;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_sel = 4'hF; wbs_adr = 10'h005;
    wb_q.push_back(32'hDEADBEEF);
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (c <= 8) begin
        checks++; if (core_gnt !== 1'b1 || sram_addr !== 10'h001 || wbs_ack !== 1'b0) begin
          failures++; $display("FAIL starve_core_c%0d: got gnt=%b addr=%h ack=%b required 1 001 0", c, core_gnt, sram_addr, wbs_ack); end
      end else if (c == 9) begin
        checks++; if (core_gnt !== 1'b0 || sram_en !== 1'b1 || sram_addr !== 10'h005) begin
          failures++; $display("FAIL starve_wb_gnt: got gnt=%b en=%b addr=%h required 0 1 005", core_gnt, sram_en, sram_addr); end
      end else begin
        e = wb_q.pop_front();
        checks++; if (wbs_ack !== 1'b1 || wbs_dat_r !== e) begin
          failures++; $display("FAIL starve_wb_ack: got ack=%b dat=%h required 1 %h", wbs_ack, wbs_dat_r, e); end
        checks++; if (core_gnt !== 1'b1) begin failures++; $display("FAIL ack_cycle_core_gnt: got %b required 1", core_gnt); end
      end
      exp_rv = (c >= 2 && c <= 9);
      checks++; if (core_rvalid !== exp_rv) begin failures++; $display("FAIL starve_rvalid_c%0d: got %b required %b", c, core_rvalid, exp_rv); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_cyc_drop;
    int n;
    logic found;
    logic [31:0] e;
    @(negedge clk);
    core_req = 1; core_we = 0; core_be = 4'hF; core_addr = 10'h010;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_sel = 4'hF; wbs_adr = 10'h011;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (core_gnt !== 1'b1 || sram_addr !== 10'h010) begin failures++; $display("FAIL drop_pre_c%0d: got gnt=%b addr=%h required 1 010", c, core_gnt, sram_addr); end
      @(negedge clk);
    end
    wbs_cyc = 0; wbs_stb = 0;
    #1;
    checks++; if (sram_addr !== 10'h010 || core_gnt !== 1'b1) begin failures++; $display("FAIL drop_no_wb: got addr=%h gnt=%b required 010 1", sram_addr, core_gnt); end
    @(negedge clk);
    wbs_cyc = 1; wbs_stb = 1;
    wb_q.push_back(32'hA5A50001);
    n = 0; found = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      #1;
      if (!core_gnt && sram_en && sram_addr == 10'h011) begin found = 1; n = c; end
      else @(negedge clk);
    end
    checks++; if (n !== 9) begin failures++; $display("FAIL drop_wait_cleared: got wb grant at cycle %0d required 9", n); end
    @(negedge clk); #1;
    e = wb_q.pop_front();
    checks++; if (wbs_ack !== 1'b1 || wbs_dat_r !== e) begin failures++; $display("FAIL drop_wb_ack: got ack=%b dat=%h required 1 %h", wbs_ack, wbs_dat_r, e); end
    idle_inputs();
  endtask

  task automatic test_reset_midgrant;
    @(negedge clk);
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'hF; wbs_adr = 10'h020; wbs_dat_w = 32'hCAFEF00D;
    #1;
    checks++; if (sram_en !== 1'b1) begin failures++; $display("FAIL rstmid_grant: got en=%b required 1", sram_en); end
    #1 rst_n = 0;
    #1;
    checks++; if (sram_en !== 1'b0 || wbs_ack !== 1'b0 || core_rvalid !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs: got en=%b ack=%b rvalid=%b required 0 0 0", sram_en, wbs_ack, core_rvalid); end
    @(negedge clk); #1;
    checks++; if (wbs_ack !== 1'b0) begin failures++; $display("FAIL rstmid_no_ack: got %b required 0", wbs_ack); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 10'h020) begin
      failures++; $display("FAIL rstmid_retry_grant: got en=%b we=%b addr=%h required 1 1 020", sram_en, sram_we, sram_addr); end
    @(negedge clk); #1;
    checks++; if (wbs_ack !== 1'b1) begin failures++; $display("FAIL rstmid_retry_ack: got %b required 1", wbs_ack); end
    idle_inputs();
    wb_read_check(10'h020, 32'hCAFEF00D, "rstmid_readback");
  endtask

  task automatic test_conflict;
    logic [15:0] exp;
`ifdef CORE_SRAM_ARB_CONFLICT_CNT_EN
    exp = 16'd3;
`else
    exp = 16'd0;
`endif
    idle_inputs();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    core_req = 1; core_we = 0; core_be = 4'hF; core_addr = 10'h010;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_sel = 4'hF; wbs_adr = 10'h011;
    repeat (3) @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (conflict_cnt !== exp) begin failures++; $display("FAIL conflict_cnt: got %0d required %0d", conflict_cnt, exp); end
    @(negedge clk); #1;
    checks++; if (conflict_cnt !== exp) begin failures++; $display("FAIL conflict_hold: got %0d required %0d", conflict_cnt, exp); end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_wb_write_read();
    test_back_to_back();
    test_starvation();
    test_cyc_drop();
    test_reset_midgrant();
    test_conflict();
    checks++;
    if (core_q.size() != 0 || wb_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got core=%0d wb=%0d entries left required 0 0", core_q.size(), wb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_sram_arbiter.md
CORE_SRAM_ARBITER -- requirements
Module: core_sram_arbiter
Interface
REQ-001 Param AW, 10, SRAM word-address width.
REQ-002 Param MAX_WAIT, 8, max consecutive cycles a pending Wishbone request loses to the core.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 wbs_cyc_i / wbs_stb_i  in  1 each  Wishbone cycle/strobe; request = cyc&stb, held until ack.
REQ-006 wbs_we_i  in  1  Wishbone write enable.
REQ-007 wbs_sel_i  in  4  Wishbone byte selects.
REQ-008 wbs_adr_i  in  AW  Wishbone word address.
REQ-009 wbs_dat_i  in  32  Wishbone write data.
REQ-010 wbs_dat_o  out  32  Wishbone read data, valid with ack.
REQ-011 wbs_ack_o  out  1  Wishbone acknowledge.
REQ-012 core_req_i  in  1  core data request.
REQ-013 core_we_i  in  1  core write enable.
REQ-014 core_be_i  in  4  core byte enables.
REQ-015 core_addr_i  in  AW  core word address.
REQ-016 core_wdata_i  in  32  core write data.
REQ-017 core_gnt_o  out  1  core grant, same cycle as accepted request.
REQ-018 core_rvalid_o  out  1  core response valid, one cycle after grant.
REQ-019 core_rdata_o  out  32  core read data, valid with rvalid.
REQ-020 sram_en_o / sram_we_o  out  1 each  SRAM access enable / write enable.
REQ-021 sram_be_o  out  4  SRAM byte enables.
REQ-022 sram_addr_o  out  AW  SRAM word address.
REQ-023 sram_wdata_o  out  32  SRAM write data.
REQ-024 sram_rdata_i  in  32  SRAM read data, valid cycle after sram_en_o.
REQ-025 conflict_cnt_o  out  16  contention counter (see Configuration).
Function
REQ-026 FSM states IDLE, WB_ACK; wb_req = cyc&stb&(state==IDLE); starve = (wait_cnt == MAX_WAIT).
REQ-027 Grant WB when wb_req & (!core_req_i | starve); else grant core when core_req_i; at most one grant per cycle.
REQ-028 Granted side's addr/be/we/wdata drive sram_* combinationally with sram_en_o=1; no grant -> all sram_* = 0.
REQ-029 WB grant: IDLE -> WB_ACK; in WB_ACK, wbs_ack_o=1 for exactly one cycle, then -> IDLE.
REQ-030 In WB_ACK: wbs_dat_o = sram_rdata_i for reads, 0 for writes; wbs_dat_o = 0 outside WB_ACK.
REQ-031 In WB_ACK wb_req is 0, so the core may be granted in the ack cycle.
REQ-032 wait_cnt (width clog2(MAX_WAIT+1)) increments when wb_req and core granted, saturates at MAX_WAIT, clears on WB grant or wb_req low.
REQ-033 core_rvalid_o registered: 1 the cycle after every core grant (read or write); core_rdata_o = sram_rdata_i when rvalid, else 0.
REQ-034 Core back-to-back grants allowed every cycle; rvalid may be high on consecutive cycles.
REQ-035 cyc/stb dropped before grant: no SRAM access, wait_cnt clears.
Reset
REQ-036 rst_ni low asynchronously forces state IDLE, wait_cnt 0, wbs_ack_o 0, core_rvalid_o 0, conflict count 0; in-flight ack/rvalid dropped, requester retries.
REQ-037 Release of rst_ni takes effect at the next clk_i rising edge; first grant possible that cycle.
Configuration
REQ-038 CORE_SRAM_ARB_CONFLICT_CNT_EN defined: conflict_cnt_o counts cycles with wb_req & core_req_i, saturating at 16'hFFFF; undefined: conflict_cnt_o tied to 0, no counter flops.
Verification
REQ-039 SRAM[0x005]=0xDEADBEEF, core read 0x005 -> core_gnt_o same cycle, core_rvalid_o=1 and core_rdata_o=0xDEADBEEF next cycle.
REQ-040 WB write adr 0x3FF sel 0xF dat 0x12345678, core idle -> sram_we_o cycle N, single-cycle ack N+1; WB read 0x3FF -> wbs_dat_o=0x12345678 with ack.
REQ-041 core_req_i held high, WB read pending -> core granted 8 cycles, WB granted 9th cycle (core_gnt_o=0 then), ack 10th cycle.
REQ-042 Core request in WB_ACK cycle -> core_gnt_o=1 same cycle as wbs_ack_o=1.
REQ-043 rst_ni low during WB grant cycle -> wbs_ack_o never asserts, outputs 0 immediately; retried request completes normally.
REQ-044 Macro defined, 3 contention cycles -> conflict_cnt_o=3; undefined -> conflict_cnt_o=0.
